// File: rtl/aes_pkg.sv
// Shared widths, latency and bundle types for the AES result path.
// Used by the collector and its block FIFO.
package aes_pkg;

    localparam int AES_BLK_W       = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLK   = 4;
    localparam int AES_PIP_LATENCY = 11;

    typedef struct packed {
        logic                 sel;
        logic [AES_BLK_W-1:0] data;
    } blk_t;

    typedef struct packed {
        logic valid;
        logic sel;
    } slot_t;

endpackage

// File: rtl/aes_blk_fifo.sv
// Show-ahead circular buffer of finished {sel, data} blocks.
// Head is always visible on dout; push and pop may coincide.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = AES_BLK_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    // Storage needs no reset; only pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign dout  = mem[rp];
    assign empty = (count == '0);

endmodule

// File: rtl/aes_out_collector.sv
// Tracks live slots of the unstallable AES pipeline, buffers results
// and streams them as big-endian 32-bit words under credit control.
module aes_out_collector
    import aes_pkg::*;
#(
    parameter int LATENCY    = AES_PIP_LATENCY,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue,
    input  logic                 issue_sel,
    input  logic [AES_BLK_W-1:0] pipe_out,
    output logic                 can_issue,
    output logic [WORD_W-1:0]    m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 m_sel,
    output logic                 overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] LAST_W = 2'(WORDS_PER_BLK - 1);

    slot_t          dl [LATENCY];
    logic [CW-1:0]  credits;
    logic [1:0]     w;
    blk_t           head;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           unused_count;
    logic           accept;
    logic           hs;
    logic           drain;

    assign accept       = issue & can_issue;
    assign hs           = m_valid & m_ready;
    assign drain        = hs & (w == LAST_W);
    assign can_issue    = (credits != '0);
    assign m_valid      = !fifo_empty;
    assign unused_count = ^fifo_count;

    aes_blk_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (AES_BLK_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (dl[LATENCY-1].valid),
        .din   ({dl[LATENCY-1].sel, pipe_out}),
        .pop   (drain),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Shadow the pipeline: a valid tap means pipe_out is a real result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
        end else begin
            dl[0] <= '{valid: accept, sel: issue_sel};
            for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
        end
    end

    // Credits = free slots minus blocks still in the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CW'(FIFO_DEPTH);
        end else if (accept && !drain) begin
            credits <= credits - 1'b1;
        end else if (!accept && drain) begin
            credits <= credits + 1'b1;
        end
    end

    // Sticky flag for an issue attempted without a credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (issue && !can_issue) begin
            overflow <= 1'b1;
        end
    end

    // Word index within the head block; wraps as the head pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w <= '0;
        end else if (hs) begin
            w <= w + 2'd1;
        end
    end

    // Select the current big-endian word; quiet zeros when idle.
    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        m_sel  = 1'b0;
        if (m_valid) begin
            m_data = head.data[AES_BLK_W-1-WORD_W*w -: WORD_W];
            m_last = (w == LAST_W);
            m_sel  = head.sel;
        end
    end

endmodule

// File: tb/tb_aes_out_collector.sv
// Randomised scoreboard bench for aes_out_collector.
// The bench plays the AES pipeline by scheduling pipe_out values.
module tb_aes_out_collector;

    localparam int LAT   = 11;
    localparam int DEPTH = 4;
    localparam logic [127:0] BAD = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    localparam logic [127:0] V1  = 128'h7206720946c642f34a3f00ccfb373457;
    localparam logic [127:0] V0  = 128'h471667611c17e6379be53e30f5ef5cdd;
    localparam logic [127:0] V2  = 128'h4874b6241ea8b1031cb5113ca9ee1e54;

    logic         clk = 1'b0;
    logic         rst;
    logic         issue;
    logic         issue_sel;
    logic [127:0] pipe_out;
    logic         can_issue;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         m_sel;
    logic         overflow;

    typedef struct {
        logic [31:0] d;
        bit          last;
        bit          sel;
    } word_t;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           outstanding = 0;
    bit           ovf_exp = 0;
    word_t        exp_q[$];
    logic [127:0] sched[int];

    aes_out_collector #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .issue_sel (issue_sel),
        .pipe_out  (pipe_out),
        .can_issue (can_issue),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_sel     (m_sel),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     n, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle: check model state, drive inputs, update model, advance.
    task automatic step(input bit iss, input bit s, input bit rdy,
                        input logic [127:0] d);
        chk("can_issue", can_issue, outstanding < DEPTH);
        chk("overflow", overflow, ovf_exp);
        pipe_out  = sched.exists(cyc) ? sched[cyc] : junk();
        issue     = iss;
        issue_sel = s;
        m_ready   = rdy;
        if (iss) begin
            if (outstanding < DEPTH) begin
                outstanding++;
                sched[cyc + LAT] = d;
                for (int i = 0; i < 4; i++)
                    exp_q.push_back('{d: d[127-32*i -: 32],
                                      last: (i == 3), sel: s});
            end else begin
                ovf_exp = 1;
                sched[cyc + LAT] = BAD;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: compares every accepted word against the scoreboard.
    bit          stall_prev = 0;
    logic [31:0] pd;
    bit          pl;
    bit          ps;
    word_t       e;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_word", {m_data, m_last, m_sel}, {pd, pl, ps});
            end
            if (!m_valid)
                chk("idle_zero", {m_data, m_last, m_sel}, 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected none (cycle %0d)",
                             m_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {m_data, m_last, m_sel}, {e.d, e.last, e.sel});
                    if (e.last) outstanding--;
                end
            end
            stall_prev = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            ps = m_sel;
        end
    end

    initial begin
        int  t;
        int  guard;
        bit  done4;
        bit  iss;
        rst = 1; issue = 0; issue_sel = 0; m_ready = 0; pipe_out = '0;
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_can_issue", can_issue, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_data", {m_data, m_last, m_sel}, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (5) step(0, 0, 1, '0);

        // Single block: latency and word order.
        t = cyc;
        step(1, 0, 1, V1);
        repeat (19) begin
            chk("t1_valid", m_valid, (cyc >= t+12) && (cyc <= t+15));
            chk("t1_last", m_last, cyc == t+15);
            step(0, 0, 1, '0);
        end

        // Back-to-back: twelve contiguous words.
        t = cyc;
        step(1, 0, 1, V0);
        step(1, 0, 1, V1);
        step(1, 1, 1, V2);
        repeat (26) begin
            chk("t2_valid", m_valid, (cyc >= t+12) && (cyc <= t+23));
            step(0, 0, 1, '0);
        end

        // Backpressure: credits run out, head word held.
        t = cyc;
        for (int i = 0; i < 20; i++) begin
            if (cyc >= t + 12) chk("t3_hold", m_data, 32'h72067209);
            step(1, $urandom_range(0, 1), 0, (i == 0) ? V1 : rnd128());
        end

        // Release; issue exactly when a last word drains at credits=1.
        done4 = 0;
        for (int i = 0; i < 40; i++) begin
            iss = !done4 && outstanding == DEPTH-1 && m_valid && m_last;
            if (iss) done4 = 1;
            step(iss, $urandom_range(0, 1), 1, rnd128());
        end
        chk("t4_hit", done4, 1);
        repeat (20) step(0, 0, 1, '0);

        // Violation: issue without credit.
        guard = 0;
        while (outstanding < DEPTH && guard < 10) begin
            step(1, $urandom_range(0, 1), 0, rnd128());
            guard++;
        end
        step(1, 1, 0, rnd128());
        repeat (60) step(0, 0, 1, '0);
        chk("t5_drained", exp_q.size(), 0);

        // Random traffic with occasional violations.
        for (int i = 0; i < 400; i++) begin
            iss = ($urandom_range(0, 1) == 1);
            if (iss && outstanding >= DEPTH && $urandom_range(0, 9) != 0)
                iss = 0;
            step(iss, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 rnd128());
        end
        repeat (80) step(0, 0, 1, '0);
        chk("rand_drained", exp_q.size(), 0);

        // Reset mid-operation.
        t = cyc;
        step(1, 0, 1, rnd128());
        while (cyc < t + 8) step(0, 0, 1, '0);
        step(1, 1, 1, rnd128());
        step(1, 0, 1, rnd128());
        while (cyc < t + 14) step(0, 0, 1, '0);
        chk("t6_mid_valid", m_valid, 1);
        rst = 1;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_can_issue", can_issue, 1);
        chk("t6_rst_overflow", overflow, 0);
        exp_q.delete();
        sched.delete();
        outstanding = 0;
        ovf_exp = 0;
        @(posedge clk); #1;
        cyc++;
        rst = 0;
        repeat (20) begin
            chk("t6_quiet", m_valid, 0);
            step(0, 0, 1, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_out_collector.md
Name: aes_out_collector

Overview:
- Sits directly downstream of aes128_pip.
- aes128_pip has no valid or stall signals. This block tracks which pipeline slots carry real blocks using a valid/sel delay line, and captures each finished 128-bit result into a small FIFO.
- It serialises each result onto a 32-bit valid/ready stream.
- It issues credits upstream (can_issue) so the non-stallable pipeline can never overrun the FIFO.

Parameters:
- LATENCY, 11: cycles from a block's `in` being sampled by aes128_pip to its result appearing on `out`. Must equal the pipeline register depth.
- FIFO_DEPTH, 4: result slots. Power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- issue  in  1  a real block is presented to aes128_pip `in` this cycle.
- issue_sel  in  1  value of aes128_pip `sel` for that block (0 = encrypt, 1 = decrypt).
- pipe_out  in  128  aes128_pip `out`.
- can_issue  out  1  upstream may assert issue this cycle.
- m_data  out  32  output word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the word.
- m_last  out  1  high on the 4th word of a block.
- m_sel  out  1  sel of the block being output.
- overflow  out  1  sticky protocol-error flag.

Behaviour:
- Reset values (asynchronous, take effect immediately on rst):
  - delay line cleared, FIFO pointers and count at 0, word counter 0, credits = FIFO_DEPTH;
  - m_valid=0, m_data=0, m_last=0, m_sel=0, can_issue=1, overflow=0.
- Reset mid-operation discards all in-flight and buffered blocks. No stale word appears after rst is released.
- Delay line:
  - LATENCY-deep shift register of {valid, sel}. Stage 0 loads {issue & can_issue, issue_sel}.
  - Tap LATENCY-1 being valid means pipe_out holds that block's result in the current cycle. The block writes {pipe_out, sel} into the FIFO at the end of that cycle.
- Latency: issue in cycle c → pipe_out captured at the end of cycle c+LATENCY → m_valid in cycle c+LATENCY+1, provided the FIFO was empty and the serialiser idle.
- Credits:
  - can_issue = (credits != 0), combinational from the register.
  - An accepted issue decrements credits. Acceptance of the last word (m_valid & m_ready & m_last) increments it.
  - Both in the same cycle: credits unchanged.
  - Credits count free FIFO slots minus in-flight blocks, so a FIFO write is never refused.
- Protocol violation (issue=1 while can_issue=0):
  - the issue is not entered into the delay line;
  - overflow is set and held until rst;
  - the corresponding pipe_out result is never output.
- FIFO:
  - circular buffer with show-ahead head; write and read in the same cycle allowed;
  - pointers wrap modulo FIFO_DEPTH.
  - A full FIFO with a pending write is unreachable by construction.
- Serialiser:
  - m_valid = FIFO non-empty.
  - 2-bit word counter w selects head bits [127-32w -: 32], so word 0 = bits [127:96] (big-endian).
  - m_last = (w==3). m_sel = head sel.
  - w advances on m_valid & m_ready. On w==3 it wraps to 0 and the head is popped.
  - With m_ready held high, one word per cycle; back-to-back blocks have no bubble.
  - m_data, m_last and m_sel are stable while m_valid & !m_ready.
  - m_data, m_last and m_sel are driven 0 when m_valid=0.

Decomposition:
- Shared package aes_pkg: AES_BLK_W=128, WORD_W=32, WORDS_PER_BLK=4, AES_PIP_LATENCY=11 (default for LATENCY).
- One sub-module: aes_blk_fifo, a 129-bit wide ({sel, data}), FIFO_DEPTH-deep show-ahead FIFO with push, pop, empty and count.
- The delay line, credit counter and serialiser stay in the top module.

Test Plan:
1. Single block:
   - Stimulus: issue=1, sel=0 in cycle 5; bench drives pipe_out=128'h7206720946c642f34a3f00ccfb373457 in cycle 16; m_ready=1.
   - Response: m_valid cycles 17–20 with words 72067209, 46c642f3, 4a3f00cc, fb373457; m_last only in cycle 20; m_sel=0.
2. Back-to-back:
   - Stimulus: issue in three consecutive cycles with sel 0, 0, 1; pipe_out 471667611c17e6379be53e30f5ef5cdd, 7206...3457, 4874b6241ea8b1031cb5113ca9ee1e54.
   - Response: 12 contiguous words in that order; m_sel 0,0,1 per block; no gap cycles.
3. Backpressure and credits:
   - Stimulus: m_ready=0; issue every cycle.
   - Response: exactly 4 issues accepted; can_issue=0 from the 5th cycle. m_data is held at 72067209 (first word of block 1) while stalled.
   - After m_ready=1, can_issue returns to 1 in the cycle after block 1's 4th word is accepted.
4. Simultaneous issue and last-word drain at credits=1:
   - Response: credits stays 1; can_issue stays 1; no overflow.
5. Violation:
   - Stimulus: issue=1 with can_issue=0.
   - Response: overflow=1 and sticky; that slot's pipe_out (bench drives deadbeef…) never appears on m_data; all other blocks intact.
6. Reset mid-operation:
   - Stimulus: rst pulsed with 2 blocks in flight and one block half-drained.
   - Response: m_valid=0 and can_issue=1 immediately; no output in the 20 cycles after release.
